// File: rtl/hera_pkg.sv
// rtl/hera_pkg.sv - shared constants for the HERA multiply/divide unit
package hera_pkg;

    localparam logic [2:0] MD_MUL_LO  = 3'd0;
    localparam logic [2:0] MD_MUL_HI  = 3'd1;
    localparam logic [2:0] MD_MUL_FIX = 3'd2;
    localparam logic [2:0] MD_MULU_LO = 3'd3;
    localparam logic [2:0] MD_DIV     = 3'd4;
    localparam logic [2:0] MD_REM     = 3'd5;
    localparam logic [2:0] MD_DIVU    = 3'd6;
    localparam logic [2:0] MD_REMU    = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    // Bit positions inside the core's flag register
    localparam int FL_C = 0;
    localparam int FL_V = 1;
    localparam int FL_Z = 2;
    localparam int FL_S = 3;

    function automatic logic mode_is_div(input logic [2:0] m);
        return m[2];
    endfunction

    function automatic logic mode_is_signed(input logic [2:0] m);
        return !(m == MD_MULU_LO || m == MD_DIVU || m == MD_REMU);
    endfunction

endpackage

// File: rtl/hera_muldiv_step.sv
// rtl/hera_muldiv_step.sv - one shift-add multiply or restoring-divide iteration
module hera_muldiv_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] sreg_i,
    input  logic [WIDTH-1:0] opnd_i,
    input  logic             is_div_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] sreg_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_t;
    logic [WIDTH-1:0] diff;

    always_comb begin
        sum    = {1'b0, acc_i} + {1'b0, opnd_i};
        rem_t  = {acc_i, sreg_i[WIDTH-1]};
        // The partial remainder stays below the divisor, so the true difference fits in WIDTH bits
        diff   = rem_t[WIDTH-1:0] - opnd_i;
        acc_o  = acc_i;
        sreg_o = sreg_i;
        if (is_div_i) begin
            if (rem_t >= {1'b0, opnd_i}) begin
                acc_o  = diff;
                sreg_o = {sreg_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o  = rem_t[WIDTH-1:0];
                sreg_o = {sreg_i[WIDTH-2:0], 1'b0};
            end
        end else if (sreg_i[0]) begin
            acc_o  = sum[WIDTH:1];
            sreg_o = {sum[0], sreg_i[WIDTH-1:1]};
        end else begin
            acc_o  = {1'b0, acc_i[WIDTH-1:1]};
            sreg_o = {acc_i[0], sreg_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/hera_muldiv.sv
// rtl/hera_muldiv.sv - iterative multiply/divide unit with HERA c/v/z/s flags
module hera_muldiv
    import hera_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_z,
    output logic             flag_s
);

    localparam int CW = $clog2(WIDTH);
    localparam int W2 = 2 * WIDTH;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q,   state_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic [WIDTH-1:0] acc_q,     acc_d;
    logic [WIDTH-1:0] sreg_q,    sreg_d;
    logic [WIDTH-1:0] opnd_q,    opnd_d;
    logic [WIDTH-1:0] a_q,       a_d;
    logic [2:0]       mode_q,    mode_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             divz_q,    divz_d;
    logic             ovf_q,     ovf_d;
    logic [WIDTH-1:0] result_q,  result_d;
    logic [3:0]       flags_q,   flags_d;
    logic             done_q,    done_d;

    logic [WIDTH-1:0] acc_step, sreg_step;
    logic             is_div_q;

    logic             in_signed, in_div, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    logic [W2-1:0]    prod, prod_s, hi_lo, hi_fix;
    logic [WIDTH-1:0] quo, rem;
    logic [WIDTH-1:0] res_fin;
    logic [3:0]       flags_fin;

    assign is_div_q = mode_is_div(mode_q);

    hera_muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc_i    (acc_q),
        .sreg_i   (sreg_q),
        .opnd_i   (opnd_q),
        .is_div_i (is_div_q),
        .acc_o    (acc_step),
        .sreg_o   (sreg_step)
    );

    // Operand magnitudes for the unsigned core; the signs are re-applied in FINISH
    always_comb begin
        in_signed = mode_is_signed(mode);
        in_div    = mode_is_div(mode);
        a_neg     = in_signed & a[WIDTH-1];
        b_neg     = in_signed & b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
    end

    always_comb begin
        prod   = {acc_q, sreg_q};
        prod_s = neg_res_q ? -prod : prod;
        quo    = neg_res_q ? -sreg_q : sreg_q;
        rem    = neg_rem_q ? -acc_q : acc_q;
        // Sign-extended high slices: representable iff every bit equals the sign
        hi_lo  = $signed(prod_s) >>> (WIDTH - 1);
        hi_fix = $signed(prod_s) >>> (WIDTH - 1 + FRAC);
    end

    always_comb begin
        res_fin   = '0;
        flags_fin = '0;
        if (is_div_q) begin
            if (mode_q == MD_DIV || mode_q == MD_DIVU) begin
                res_fin = divz_q ? '1 : quo;
            end else begin
                res_fin = divz_q ? a_q : rem;
            end
            flags_fin[FL_C] = divz_q;
            flags_fin[FL_V] = ovf_q;
            flags_fin[FL_Z] = (res_fin == '0);
            flags_fin[FL_S] = res_fin[WIDTH-1];
        end else begin
            flags_fin[FL_Z] = (prod_s == '0);
            flags_fin[FL_S] = prod_s[W2-1];
            case (mode_q)
                MD_MUL_LO: begin
                    res_fin         = prod_s[WIDTH-1:0];
                    flags_fin[FL_V] = !(hi_lo == '0 || hi_lo == '1);
                end
                MD_MUL_HI: begin
                    res_fin         = prod_s[W2-1:WIDTH];
                    flags_fin[FL_V] = !(hi_lo == '0 || hi_lo == '1);
                end
                MD_MUL_FIX: begin
                    res_fin         = prod_s[WIDTH-1+FRAC -: WIDTH];
                    flags_fin[FL_V] = !(hi_fix == '0 || hi_fix == '1);
                end
                default: begin
                    res_fin         = prod_s[WIDTH-1:0];
                    flags_fin[FL_C] = (prod_s[W2-1:WIDTH] != '0);
                    flags_fin[FL_S] = prod_s[WIDTH-1];
                end
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        sreg_d    = sreg_q;
        opnd_d    = opnd_q;
        a_d       = a_q;
        mode_d    = mode_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        divz_d    = divz_q;
        ovf_d     = ovf_q;
        result_d  = result_q;
        flags_d   = flags_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    cnt_d     = '0;
                    acc_d     = '0;
                    mode_d    = mode;
                    a_d       = a;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = in_div & a_neg;
                    divz_d    = in_div & (b == '0);
                    ovf_d     = in_div & in_signed & (a == MOST_NEG) & (b == '1);
                    // Divide shifts the dividend out of sreg; multiply shifts the multiplier
                    sreg_d    = in_div ? a_mag : b_mag;
                    opnd_d    = in_div ? b_mag : a_mag;
                end
            end
            ST_RUN: begin
                acc_d  = acc_step;
                sreg_d = sreg_step;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                result_d = res_fin;
                flags_d  = flags_fin;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            sreg_q    <= '0;
            opnd_q    <= '0;
            a_q       <= '0;
            mode_q    <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            divz_q    <= 1'b0;
            ovf_q     <= 1'b0;
            result_q  <= '0;
            flags_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            sreg_q    <= sreg_d;
            opnd_q    <= opnd_d;
            a_q       <= a_d;
            mode_q    <= mode_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            divz_q    <= divz_d;
            ovf_q     <= ovf_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
            done_q    <= done_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;
    assign result = result_q;
    assign flag_c = flags_q[FL_C];
    assign flag_v = flags_q[FL_V];
    assign flag_z = flags_q[FL_Z];
    assign flag_s = flags_q[FL_S];

endmodule

// File: tb/tb_hera_muldiv.sv
// tb/tb_hera_muldiv.sv - directed self-checking bench for hera_muldiv
module tb_hera_muldiv;
    import hera_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  mode  = '0;
    logic [15:0] a     = '0;
    logic [15:0] b     = '0;
    logic        busy, done;
    logic [15:0] result;
    logic        flag_c, flag_v, flag_z, flag_s;

    int errors = 0;
    int checks = 0;

    hera_muldiv #(.WIDTH(16), .FRAC(8)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .mode   (mode),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .flag_c (flag_c),
        .flag_v (flag_v),
        .flag_z (flag_z),
        .flag_s (flag_s)
    );

    always #5 clock = ~clock;

    function automatic logic [3:0] flags_now();
        return {flag_c, flag_v, flag_z, flag_s};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the sampling edge
    task automatic launch(input logic [2:0] m, input logic [15:0] x, input logic [15:0] y);
        start = 1'b1;
        mode  = m;
        a     = x;
        b     = y;
        @(negedge clock);
        start = 1'b0;
        a     = 16'hDEAD;
        b     = 16'hBEEF;
    endtask

    // n counts rising edges from the sampling edge (inclusive) until done is seen
    task automatic wait_done(output int n);
        n = 1;
        while (!done && n < 40) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic run_check(input string tag, input logic [2:0] m, input logic [15:0] x,
                             input logic [15:0] y, input logic [15:0] er, input logic [3:0] ef);
        int n;
        @(negedge clock);
        launch(m, x, y);
        chk({tag, " busy"}, busy, 1'b1);
        wait_done(n);
        chk({tag, " latency"}, n, 18);
        chk({tag, " busy_at_done"}, busy, 1'b0);
        chk({tag, " result"}, result, er);
        chk({tag, " flags_cvzs"}, flags_now(), ef);
        @(negedge clock);
        chk({tag, " done_pulse"}, done, 1'b0);
    endtask

    initial begin
        int n;
        int seen;

        repeat (3) @(negedge clock);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset result", result, 16'h0000);
        chk("reset flags", flags_now(), 4'b0000);
        reset = 1'b0;

        //        tag          mode        a         b         result    {c,v,z,s}
        run_check("mul_lo",    MD_MUL_LO,  16'h0003, 16'hFFFE, 16'hFFFA, 4'b0001);
        run_check("mul_lo_ov", MD_MUL_LO,  16'h0100, 16'h0100, 16'h0000, 4'b0100);
        run_check("mul_hi",    MD_MUL_HI,  16'h4000, 16'h0004, 16'h0001, 4'b0100);
        run_check("mul_hi_nn", MD_MUL_HI,  16'hFFFF, 16'hFFFF, 16'h0000, 4'b0000);
        run_check("mulu_lo",   MD_MULU_LO, 16'hFFFF, 16'h0002, 16'hFFFE, 4'b1001);
        run_check("mul_fix",   MD_MUL_FIX, 16'h0180, 16'h0200, 16'h0300, 4'b0000);
        run_check("mul_fix_v", MD_MUL_FIX, 16'h7F00, 16'h0200, 16'hFE00, 4'b0100);
        run_check("div",       MD_DIV,     16'hFFF9, 16'h0002, 16'hFFFD, 4'b0001);
        run_check("rem",       MD_REM,     16'hFFF9, 16'h0002, 16'hFFFF, 4'b0001);
        run_check("divu_z",    MD_DIVU,    16'h1234, 16'h0000, 16'hFFFF, 4'b1001);
        run_check("remu_z",    MD_REMU,    16'h1234, 16'h0000, 16'h1234, 4'b1000);
        run_check("div_sz",    MD_DIV,     16'hFFF9, 16'h0000, 16'hFFFF, 4'b1001);
        run_check("rem_sz",    MD_REM,     16'hFFF9, 16'h0000, 16'hFFF9, 4'b1001);
        run_check("div_ovf",   MD_DIV,     16'h8000, 16'hFFFF, 16'h8000, 4'b0101);
        run_check("rem_ovf",   MD_REM,     16'h8000, 16'hFFFF, 16'h0000, 4'b0110);
        run_check("divu",      MD_DIVU,    16'h0064, 16'h0007, 16'h000E, 4'b0000);

        // start while busy is dropped, not queued
        @(negedge clock);
        launch(MD_MUL_LO, 16'h0003, 16'hFFFE);
        n = 1;
        while (!done && n < 40) begin
            @(negedge clock);
            n++;
            if (n == 5) begin
                start = 1'b1;
                mode  = MD_MULU_LO;
                a     = 16'h0005;
                b     = 16'h0005;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("ign latency", n, 18);
        chk("ign result", result, 16'hFFFA);
        seen = 0;
        repeat (25) begin
            @(negedge clock);
            if (done) seen++;
        end
        chk("ign extra_done", seen, 0);
        chk("ign result_held", result, 16'hFFFA);

        // reset in the middle of a run
        @(negedge clock);
        launch(MD_DIVU, 16'h1234, 16'h0007);
        n = 1;
        while (n < 8) begin
            @(negedge clock);
            n++;
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst result", result, 16'h0000);
        chk("rst flags", flags_now(), 4'b0000);
        seen = 0;
        repeat (25) begin
            @(negedge clock);
            if (done) seen++;
        end
        chk("rst no_done", seen, 0);

        // back-to-back: new start issued in the done cycle
        @(negedge clock);
        launch(MD_MUL_LO, 16'h0003, 16'hFFFE);
        wait_done(n);
        chk("b2b first_done", done, 1'b1);
        chk("b2b first_result", result, 16'hFFFA);
        launch(MD_DIVU, 16'h0064, 16'h0007);
        chk("b2b busy", busy, 1'b1);
        wait_done(n);
        chk("b2b latency", n, 18);
        chk("b2b result", result, 16'h000E);
        chk("b2b flags", flags_now(), 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
